ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
Round-robin arbiter that shares one single-port RAM (8-bit data, 8-bit address, synchronous write, registered read) between two requesters. Each requester issues single-word read or write commands over a req/gnt handshake. Read data returns on a per-port tagged response. The block sits between the two client engines and the single-port RAM instance, and owns all RAM control pins.

Parameters:
DW, 8, data width of RAM and client ports
AW, 8, address width of RAM and client ports
RD_LAT, 1, RAM read latency in cycles from command on ram_addr to valid ram_dout (1..4)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
req0  input  1  port 0 command request, held until granted
we0  input  1  port 0 command type: 1 = write, 0 = read
addr0  input  AW  port 0 address
wdata0  input  DW  port 0 write data
gnt0  output  1  port 0 command accepted this cycle (combinational)
rvalid0  output  1  port 0 read data valid, one-cycle pulse
rdata0  output  DW  port 0 read data
req1/we1/addr1/wdata1/gnt1/rvalid1/rdata1  same as port 0, for port 1
ram_we  output  1  RAM write enable
ram_addr  output  AW  RAM address
ram_din  output  DW  RAM write data
ram_dout  input  DW  RAM read data

Behaviour:
- Reset (rst low, async): ram_we=0, ram_addr=0, ram_din=0; rvalid0/1=0, rdata0/1=0. Priority pointer is set to port 0. The read-tag pipeline is cleared, so in-flight reads are dropped and produce no rvalid after reset.
- Arbitration: at most one command is accepted per cycle.
  - gntN=1 iff reqN=1 and port N wins. gnt is never high while rst is low.
  - Only one requester active: it wins.
  - Both active: the port named by the priority pointer wins.
  - Pointer update: on every grant, the pointer moves to the other port, i.e. the last winner gets low priority. With no grant, the pointer holds.
  - Both requesting continuously gives a strict alternation 0,1,0,1... No starvation: a held request is granted within 2 cycles.
- Handshake: the requester holds req/we/addr/wdata stable until it samples gnt=1 at a rising edge. It may hold req high for back-to-back commands, one per grant.
- Command issue: at the grant edge, ram_addr<=addrN, ram_din<=wdataN, ram_we<=weN. With no grant, ram_we<=0 and ram_addr/ram_din hold their values.
- Writes: ram_we is high for exactly one cycle per granted write. No response is generated.
- Reads: a tag {valid, port} enters a pipeline of depth RD_LAT+1 at the grant edge. When the tag exits, rdataN<=ram_dout and rvalidN<=1 for one cycle, for the tagged port only. Response latency is exactly RD_LAT+1 cycles after the grant edge.
  - Responses return in grant order.
  - rdataN holds its last value when rvalidN=0.
  - rvalid0 and rvalid1 are never high in the same cycle.
- Read-after-write to the same address, granted in consecutive cycles (either port), returns the new data. This relies on RAM order and needs no forwarding logic.
- Throughput: one command per cycle sustained, with reads and writes freely interleaved across ports.
- Reset deasserting mid-request: arbitration resumes with port 0 priority on the first edge after release.

Test Plan:
1. Reset, then port 0 writes 0xA5 to addr 0x03 (req0 held until gnt0) -> gnt0 high one cycle; next cycle ram_we=1, ram_addr=0x03, ram_din=0xA5; no rvalid.
2. Port 0 reads addr 0x03 after scenario 1 -> rvalid0 pulses RD_LAT+1 cycles after the gnt0 edge with rdata0=0xA5; rvalid1 stays 0.
3. Both ports hold req continuously for 8 cycles (port 0 writes addr 0x00..0x03, port 1 writes 0x10..0x13) -> grant order 0,1,0,1,...; 4 grants each; RAM contents match.
4. Port 0 writes 0x3C to addr 0x07, then port 1 reads addr 0x07 on the very next cycle -> rdata1=0x3C, rvalid1 one pulse.
5. Back-to-back reads: port 0 reads addr 0x01 and port 1 reads addr 0x02 in alternation for 10 cycles (RAM preloaded) -> responses in grant order, correct port tags, exactly one rvalid per read, never both high.
6. Assert rst low while 2 reads are in flight -> outputs go to reset values immediately, no rvalid after release, and the first grant after release goes to port 0 when both request.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one single-port RAM between two
// single-word requesters. Grants are combinational. RAM commands are
// registered at the grant edge. Read data comes back through a tag pipeline
// that marks which port each response belongs to.
module ram_port_arbiter #(
  parameter int DW     = 8,
  parameter int AW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  // A value of 1 means port 1 wins a tie. The last winner always drops to
  // low priority.
  logic          prio_reg;
  logic          prio_next;
  logic          win0;
  logic          win1;
  logic          any_win;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  logic          ram_we_reg;
  logic [AW-1:0] ram_addr_reg;
  logic [DW-1:0] ram_din_reg;

  // Read tags. Stage 0 is loaded at the grant edge. Stage RD_LAT lines up
  // with valid ram_dout, one RAM latency after the command was registered.
  logic [RD_LAT:0] tag_vld_reg;
  logic [RD_LAT:0] tag_vld_next;
  logic [RD_LAT:0] tag_port_reg;
  logic [RD_LAT:0] tag_port_next;

  logic          rvalid0_reg;
  logic          rvalid1_reg;
  logic [DW-1:0] rdata0_reg;
  logic [DW-1:0] rdata1_reg;
  logic          resp0;
  logic          resp1;

  // Arbitration, winning-command mux and pointer update. Nothing is granted
  // while reset is held.
  always_comb begin
    win0      = rst & req0 & (~req1 | ~prio_reg);
    win1      = rst & req1 & (~req0 | prio_reg);
    any_win   = win0 | win1;
    win_we    = win1 ? we1    : we0;
    win_addr  = win1 ? addr1  : addr0;
    win_wdata = win1 ? wdata1 : wdata0;
    prio_next = prio_reg;
    if (any_win) begin
      prio_next = win0;
    end
  end

  assign gnt0 = win0;
  assign gnt1 = win1;

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_reg <= 1'b0;
    end else begin
      prio_reg <= prio_next;
    end
  end

  // RAM command register. The address and data hold between grants, and the
  // write strobe lasts a single cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_we_reg   <= 1'b0;
      ram_addr_reg <= '0;
      ram_din_reg  <= '0;
    end else begin
      ram_we_reg <= any_win & win_we;
      if (any_win) begin
        ram_addr_reg <= win_addr;
        ram_din_reg  <= win_wdata;
      end
    end
  end

  assign ram_we   = ram_we_reg;
  assign ram_addr = ram_addr_reg;
  assign ram_din  = ram_din_reg;

  // Build the tag shift chain. Only granted reads create a valid tag.
  assign tag_vld_next[0]  = any_win & ~win_we;
  assign tag_port_next[0] = win1;

  genvar gi;
  generate
    for (gi = 1; gi <= RD_LAT; gi++) begin : g_tag
      assign tag_vld_next[gi]  = tag_vld_reg[gi-1];
      assign tag_port_next[gi] = tag_port_reg[gi-1];
    end
  endgenerate

  // Tag pipeline register. Reset drops every read that is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld_reg  <= '0;
      tag_port_reg <= '0;
    end else begin
      tag_vld_reg  <= tag_vld_next;
      tag_port_reg <= tag_port_next;
    end
  end

  assign resp0 = tag_vld_reg[RD_LAT] & ~tag_port_reg[RD_LAT];
  assign resp1 = tag_vld_reg[RD_LAT] &  tag_port_reg[RD_LAT];

  // Response registers. Only the tagged port captures ram_dout. Read data
  // holds its value between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid0_reg <= 1'b0;
      rvalid1_reg <= 1'b0;
      rdata0_reg  <= '0;
      rdata1_reg  <= '0;
    end else begin
      rvalid0_reg <= resp0;
      rvalid1_reg <= resp1;
      if (resp0) begin
        rdata0_reg <= ram_dout;
      end
      if (resp1) begin
        rdata1_reg <= ram_dout;
      end
    end
  end

  assign rvalid0 = rvalid0_reg;
  assign rvalid1 = rvalid1_reg;
  assign rdata0  = rdata0_reg;
  assign rdata1  = rdata1_reg;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter. It drives the arbiter against a behavioural
// single-port RAM. A reference model tracks arbitration fairness, RAM
// contents and an ordered queue of expected read responses.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
  localparam int DW     = 8;
  localparam int AW     = 8;
  localparam int RD_LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Behavioural single-port RAM: synchronous write, read latency RD_LAT.
  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] dpipe [RD_LAT];
  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = '0;
  end
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    dpipe[0] <= ram_mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign ram_dout = dpipe[RD_LAT-1];

  // Reference model state.
  typedef struct {
    logic [7:0] data;
    int         port;
    int         due;
  } resp_t;
  resp_t      rq[$];
  logic [7:0] mmem [256];
  int         last_win;
  logic       exp_we;
  logic [7:0] exp_addr, exp_din, exp_rd0, exp_rd1;
  int         cyc;
  int         n_pass, n_total;
  bit         g0_s, g1_s;
  int         grant_cyc, rv_cyc0, rv_cyc1, rv_cnt0, rv_cnt1;

  typedef struct {
    bit         r0;
    bit         r1;
    logic [7:0] a0;
    logic [7:0] a1;
    bit         eg0;
    bit         eg1;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic model_reset();
    rq.delete();
    last_win = 1;
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_din  = '0;
    exp_rd0  = '0;
    exp_rd1  = '0;
  endtask

  // One clock cycle. Inputs are already driven, and this is called at the
  // negative edge.
  task automatic step();
    bit eg0, eg1, w;
    logic [7:0] a, d;
    bit e0, e1;
    #1;
    eg0 = 0; eg1 = 0;
    if (req0 && req1) begin
      if (last_win == 0) eg1 = 1; else eg0 = 1;
    end else if (req0) eg0 = 1;
    else if (req1) eg1 = 1;
    chk("gnt", {gnt0, gnt1}, {eg0, eg1});
    g0_s = gnt0; g1_s = gnt1;
    if (eg0 || eg1) begin
      w = eg1 ? we1 : we0;
      a = eg1 ? addr1 : addr0;
      d = eg1 ? wdata1 : wdata0;
      last_win = eg1 ? 1 : 0;
      exp_we = w; exp_addr = a; exp_din = d;
      if (w) mmem[a] = d;
      else rq.push_back('{data: mmem[a], port: (eg1 ? 1 : 0), due: cyc + RD_LAT + 2});
    end else begin
      exp_we = 1'b0;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (g0_s || g1_s) grant_cyc = cyc;
    chk("ram_we", ram_we, exp_we);
    chk("ram_addr", ram_addr, exp_addr);
    chk("ram_din", ram_din, exp_din);
    e0 = 0; e1 = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      if (rq[0].port == 0) begin e0 = 1; exp_rd0 = rq[0].data; end
      else begin e1 = 1; exp_rd1 = rq[0].data; end
      void'(rq.pop_front());
    end
    chk("rvalid", {rvalid0, rvalid1}, {e0, e1});
    chk("rdata0", rdata0, exp_rd0);
    chk("rdata1", rdata1, exp_rd1);
    chk("rvalid_excl", rvalid0 & rvalid1, 0);
    if (rvalid0) begin rv_cyc0 = cyc; rv_cnt0++; end
    if (rvalid1) begin rv_cyc1 = cyc; rv_cnt1++; end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic issue(input int p, input bit w, input logic [7:0] a, input logic [7:0] d);
    bit got;
    got = 0;
    if (p == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    else begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    for (int k = 0; k < 4 && !got; k++) begin
      step();
      got = (p == 0) ? g0_s : g1_s;
    end
    chk("issue_granted", got, 1);
    if (p == 0) req0 = 0; else req1 = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    chk("rst_gnt", {gnt0, gnt1}, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_rvalid", {rvalid0, rvalid1}, 0);
    chk("rst_rdata", {rdata0, rdata1}, 0);
    model_reset();
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_rvalid_held", {rvalid0, rvalid1}, 0);
    end
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, g, ng0, ng1;
    bit pend0, pend1;
    int wait0, wait1;

    vt[0] = '{r0: 1, r1: 1, a0: 8'h00, a1: 8'h10, eg0: 1, eg1: 0};
    vt[1] = '{r0: 1, r1: 1, a0: 8'h01, a1: 8'h10, eg0: 0, eg1: 1};
    vt[2] = '{r0: 1, r1: 1, a0: 8'h01, a1: 8'h11, eg0: 1, eg1: 0};
    vt[3] = '{r0: 1, r1: 1, a0: 8'h02, a1: 8'h11, eg0: 0, eg1: 1};
    vt[4] = '{r0: 1, r1: 1, a0: 8'h02, a1: 8'h12, eg0: 1, eg1: 0};
    vt[5] = '{r0: 1, r1: 1, a0: 8'h03, a1: 8'h12, eg0: 0, eg1: 1};
    vt[6] = '{r0: 1, r1: 1, a0: 8'h03, a1: 8'h13, eg0: 1, eg1: 0};
    vt[7] = '{r0: 0, r1: 1, a0: 8'h00, a1: 8'h13, eg0: 0, eg1: 1};

    n_pass = 0; n_total = 0; cyc = 0;
    rv_cnt0 = 0; rv_cnt1 = 0; rv_cyc0 = -1; rv_cyc1 = -1; grant_cyc = 0;
    for (int i = 0; i < 256; i++) mmem[i] = '0;
    rst = 1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    #2;
    do_reset();

    // Scenario 1: a single write from port 0.
    issue(0, 1, 8'h03, 8'hA5);
    chk("t1_ram_we", ram_we, 1);
    chk("t1_ram_addr", ram_addr, 8'h03);
    chk("t1_ram_din", ram_din, 8'hA5);
    idle(1);
    chk("t1_we_pulse", ram_we, 0);
    chk("t1_no_rvalid", rv_cnt0 + rv_cnt1, 0);

    // Scenario 2: read back the write.
    c1 = rv_cnt1;
    issue(0, 0, 8'h03, 8'h00);
    g = grant_cyc;
    idle(RD_LAT + 2);
    chk("t2_latency", rv_cyc0 - g, RD_LAT + 1);
    chk("t2_rdata0", rdata0, 8'hA5);
    chk("t2_no_rvalid1", rv_cnt1 - c1, 0);

    // Scenario 3: both ports request together and the grants alternate.
    do_reset();
    ng0 = 0; ng1 = 0;
    for (int i = 0; i < 8; i++) begin
      req0 = vt[i].r0; we0 = 1; addr0 = vt[i].a0; wdata0 = 8'h40 | vt[i].a0;
      req1 = vt[i].r1; we1 = 1; addr1 = vt[i].a1; wdata1 = 8'h80 | vt[i].a1;
      step();
      chk("t3_gnt_table", {g0_s, g1_s}, {vt[i].eg0, vt[i].eg1});
      ng0 += int'(g0_s); ng1 += int'(g1_s);
    end
    req0 = 0; req1 = 0;
    idle(2);
    chk("t3_grants0", ng0, 4);
    chk("t3_grants1", ng1, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_mem_p0", ram_mem[i], 8'h40 + i);
      chk("t3_mem_p1", ram_mem[8'h10 + i], 8'h90 + i);
    end

    // Scenario 4: a write from port 0 followed on the next cycle by a read
    // of the same address from port 1.
    issue(0, 1, 8'h07, 8'h3C);
    c1 = rv_cnt1;
    issue(1, 0, 8'h07, 8'h00);
    g = grant_cyc;
    idle(RD_LAT + 2);
    chk("t4_rdata1", rdata1, 8'h3C);
    chk("t4_pulses", rv_cnt1 - c1, 1);
    chk("t4_latency", rv_cyc1 - g, RD_LAT + 1);

    // Scenario 5: back-to-back alternating reads.
    c0 = rv_cnt0; c1 = rv_cnt1;
    req0 = 1; we0 = 0; addr0 = 8'h01;
    req1 = 1; we1 = 0; addr1 = 8'h02;
    idle(10);
    req0 = 0; req1 = 0;
    idle(RD_LAT + 2);
    chk("t5_resp0", rv_cnt0 - c0, 5);
    chk("t5_resp1", rv_cnt1 - c1, 5);
    chk("t5_rdata0", rdata0, 8'h41);
    chk("t5_rdata1", rdata1, 8'h42);

    // Scenario 6: reset arrives while two reads are in flight.
    issue(1, 0, 8'h10, 8'h00);
    issue(0, 0, 8'h11, 8'h00);
    c0 = rv_cnt0; c1 = rv_cnt1;
    req0 = 1; we0 = 0; addr0 = 8'h05;
    req1 = 1; we1 = 0; addr1 = 8'h06;
    do_reset();
    step();
    chk("t6_first_gnt", {g0_s, g1_s}, 2'b10);
    req0 = 0;
    step();
    chk("t6_second_gnt", g1_s, 1);
    req1 = 0;
    idle(RD_LAT + 3);
    chk("t6_resp_count", (rv_cnt0 - c0) + (rv_cnt1 - c1), 2);

    // Random traffic checked against the reference model.
    pend0 = 0; pend1 = 0; wait0 = 0; wait1 = 0;
    for (int k = 0; k < 400; k++) begin
      if (!pend0 && $urandom_range(0, 2) != 0) begin
        pend0 = 1; we0 = 1'($urandom_range(0, 1));
        addr0 = 8'($urandom_range(0, 15)); wdata0 = 8'($urandom);
      end
      if (!pend1 && $urandom_range(0, 2) != 0) begin
        pend1 = 1; we1 = 1'($urandom_range(0, 1));
        addr1 = 8'($urandom_range(0, 15)); wdata1 = 8'($urandom);
      end
      req0 = pend0; req1 = pend1;
      step();
      if (g0_s) begin pend0 = 0; wait0 = 0; end else if (pend0) wait0++;
      if (g1_s) begin pend1 = 0; wait1 = 0; end else if (pend1) wait1++;
      if (pend0) chk("starve0", wait0 < 2, 1);
      if (pend1) chk("starve1", wait1 < 2, 1);
    end
    req0 = 0; req1 = 0;
    idle(RD_LAT + 3);
    chk("rand_drained", rq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
